// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants, position type and small helpers for the
// 640x480@60Hz raster generator and its per-axis counters.
package vga_timing_pkg;

    // Both axes fit in 10 bits (800 columns, 525 lines).
    localparam int POS_W = 10;
    typedef logic [POS_W-1:0] pos_t;

    // Total period of one axis: visible area plus porches and sync.
    function automatic int axis_total(input int display, input int front,
                                      input int sync, input int back);
        return display + front + sync + back;
    endfunction

    // First position inside the sync pulse.
    function automatic int sync_start(input int display, input int front);
        return display + front;
    endfunction

    // Last position inside the sync pulse (inclusive).
    function automatic int sync_end(input int display, input int front,
                                    input int sync);
        return display + front + sync - 1;
    endfunction

    // Drive level of a sync pin given whether the position is inside the pulse.
    function automatic logic sync_level(input logic in_window, input logic active_low);
        return active_low ? ~in_window : in_window;
    endfunction

    // Default 640x480 @ 60 Hz timing (25 MHz pixel clock).
    localparam int H_DISPLAY       = 640;
    localparam int H_FRONT         = 16;
    localparam int H_SYNC          = 96;
    localparam int H_BACK          = 48;
    localparam int V_DISPLAY       = 480;
    localparam int V_FRONT         = 10;
    localparam int V_SYNC          = 2;
    localparam int V_BACK          = 33;
    localparam int SYNC_ACTIVE_LOW = 1;

    // Derived periods and sync windows for the default mode.
    localparam int H_TOTAL  = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL  = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int HS_START = sync_start(H_DISPLAY, H_FRONT);
    localparam int HS_END   = sync_end(H_DISPLAY, H_FRONT, H_SYNC);
    localparam int VS_START = sync_start(V_DISPLAY, V_FRONT);
    localparam int VS_END   = sync_end(V_DISPLAY, V_FRONT, V_SYNC);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle handed from the timing generator to the
// framebuffer fetch / colour output logic. The generator drives every
// signal (master); consumers only observe (slave). There is no
// handshake: the bundle is a free-running, always-valid broadcast that
// changes once per pixel clock, and consumers never back-pressure it.
interface vga_timing_gen_if;

    logic                  hsync;
    logic                  vsync;
    logic                  display_on;
    vga_timing_pkg::pos_t  hpos;
    vga_timing_pkg::pos_t  vpos;
    logic                  line_end;
    logic                  frame_end;

    modport master (
        output hsync, vsync, display_on, hpos, vpos, line_end, frame_end
    );

    modport slave (
        input  hsync, vsync, display_on, hpos, vpos, line_end, frame_end
    );

endinterface

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: a wrap counter over DISPLAY+FRONT+SYNC+BACK positions
// with a registered sync output. The visible-area and terminal-count
// decodes are offered from the next-state count so the parent can
// register them in step with the counter.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int DISPLAY    = 640,
    parameter int FRONT      = 16,
    parameter int SYNC       = 96,
    parameter int BACK       = 48,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic reset,          // asynchronous, active low
    input  logic en_i,           // advance the count on this clock edge
    output pos_t pos_o,          // current position
    output logic sync_o,         // registered sync level for pos_o
    output logic active_next_o,  // next position lies in the visible area
    output logic tc_next_o       // next position is the last of the period
);

    localparam pos_t LAST    = pos_t'(axis_total(DISPLAY, FRONT, SYNC, BACK) - 1);
    localparam pos_t S_START = pos_t'(sync_start(DISPLAY, FRONT));
    localparam pos_t S_END   = pos_t'(sync_end(DISPLAY, FRONT, SYNC));
    localparam pos_t DISP    = pos_t'(DISPLAY);
    localparam logic ACT_LOW = (ACTIVE_LOW != 0);

    pos_t cnt_q;
    pos_t cnt_d;
    logic sync_q;
    logic sync_d;

    // Next position (wrapping at LAST) and the sync level that goes with it.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + pos_t'(1);
            end
        end
        sync_d = sync_level((cnt_d >= S_START) && (cnt_d <= S_END), ACT_LOW);
    end

    // Counter and sync register; reset parks at position 0 with sync idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            sync_q <= sync_level(1'b0, ACT_LOW);
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= sync_d;
        end
    end

    assign pos_o         = cnt_q;
    assign sync_o        = sync_q;
    assign active_next_o = (cnt_d < DISP);
    assign tc_next_o     = (cnt_d == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator. A horizontal axis counter runs
// every pixel clock; the vertical axis advances on the clock that ends a
// line. Every output is a flop loaded from next-state decodes, so sync,
// display_on and the end pulses always describe the hpos/vpos shown in
// the same cycle.
module vga_timing_gen #(
    parameter int H_DISPLAY       = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT         = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC          = vga_timing_pkg::H_SYNC,
    parameter int H_BACK          = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY       = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT         = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC          = vga_timing_pkg::V_SYNC,
    parameter int V_BACK          = vga_timing_pkg::V_BACK,
    parameter int SYNC_ACTIVE_LOW = vga_timing_pkg::SYNC_ACTIVE_LOW
) (
    input  logic              clk,
    input  logic              reset,   // asynchronous, active low
    vga_timing_gen_if.master  vga
);
    import vga_timing_pkg::*;

    pos_t h_pos;
    pos_t v_pos;
    logic h_sync;
    logic v_sync;
    logic h_active_next;
    logic v_active_next;
    logic h_tc_next;
    logic v_tc_next;

    logic line_end_q;
    logic line_end_d;
    logic frame_end_q;
    logic frame_end_d;
    logic display_on_q;
    logic display_on_d;

    vga_axis_counter #(
        .DISPLAY    (H_DISPLAY),
        .FRONT      (H_FRONT),
        .SYNC       (H_SYNC),
        .BACK       (H_BACK),
        .ACTIVE_LOW (SYNC_ACTIVE_LOW)
    ) u_h_axis (
        .clk           (clk),
        .reset         (reset),
        .en_i          (1'b1),
        .pos_o         (h_pos),
        .sync_o        (h_sync),
        .active_next_o (h_active_next),
        .tc_next_o     (h_tc_next)
    );

    // line_end_q is high exactly while hpos sits at its last column, which
    // is the cycle whose closing edge wraps hpos and steps vpos.
    vga_axis_counter #(
        .DISPLAY    (V_DISPLAY),
        .FRONT      (V_FRONT),
        .SYNC       (V_SYNC),
        .BACK       (V_BACK),
        .ACTIVE_LOW (SYNC_ACTIVE_LOW)
    ) u_v_axis (
        .clk           (clk),
        .reset         (reset),
        .en_i          (line_end_q),
        .pos_o         (v_pos),
        .sync_o        (v_sync),
        .active_next_o (v_active_next),
        .tc_next_o     (v_tc_next)
    );

    // Combine the per-axis next-state decodes into the frame-level flags.
    always_comb begin
        line_end_d   = h_tc_next;
        frame_end_d  = h_tc_next && v_tc_next;
        display_on_d = h_active_next && v_active_next;
    end

    // Frame-level flags; reset values match position (0,0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_end_q   <= 1'b0;
            frame_end_q  <= 1'b0;
            display_on_q <= 1'b1;
        end else begin
            line_end_q   <= line_end_d;
            frame_end_q  <= frame_end_d;
            display_on_q <= display_on_d;
        end
    end

    assign vga.hsync      = h_sync;
    assign vga.vsync      = v_sync;
    assign vga.display_on = display_on_q;
    assign vga.hpos       = h_pos;
    assign vga.vpos       = v_pos;
    assign vga.line_end   = line_end_q;
    assign vga.frame_end  = frame_end_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance for horizontal
// timing, plus two reduced-geometry instances (active-low and active-high
// sync) so full frames, vertical sync and frame_end fit in a short run.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    // Reduced geometry: 15 columns x 13 lines, 195 clocks per frame.
    localparam int SH_D = 8;
    localparam int SH_F = 2;
    localparam int SH_S = 3;
    localparam int SH_B = 2;
    localparam int SV_D = 6;
    localparam int SV_F = 2;
    localparam int SV_S = 2;
    localparam int SV_B = 3;
    localparam int S_HT    = SH_D + SH_F + SH_S + SH_B;
    localparam int S_VT    = SV_D + SV_F + SV_S + SV_B;
    localparam int S_FRAME = S_HT * S_VT;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_timing_gen_if def_if ();
    vga_timing_gen_if lo_if ();
    vga_timing_gen_if hi_if ();

    vga_timing_gen dut_def (
        .clk   (clk),
        .reset (reset),
        .vga   (def_if)
    );

    vga_timing_gen #(
        .H_DISPLAY(SH_D), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_DISPLAY(SV_D), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
        .SYNC_ACTIVE_LOW(1)
    ) dut_lo (
        .clk   (clk),
        .reset (reset),
        .vga   (lo_if)
    );

    vga_timing_gen #(
        .H_DISPLAY(SH_D), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_DISPLAY(SV_D), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
        .SYNC_ACTIVE_LOW(0)
    ) dut_hi (
        .clk   (clk),
        .reset (reset),
        .vga   (hi_if)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;   // rising edges since reset release
    int hs_low = 0;
    int vs_low = 0;
    int last_fe = -1;

    // Hand-computed vectors for the default 640x480 instance.
    typedef struct { int c; int h; int v; bit hs; bit de; bit le; } def_vec_t;
    def_vec_t def_tab [10] = '{
        '{1,    1,   0, 1'b1, 1'b1, 1'b0},
        '{639,  639, 0, 1'b1, 1'b1, 1'b0},
        '{640,  640, 0, 1'b1, 1'b0, 1'b0},
        '{655,  655, 0, 1'b1, 1'b0, 1'b0},
        '{656,  656, 0, 1'b0, 1'b0, 1'b0},
        '{751,  751, 0, 1'b0, 1'b0, 1'b0},
        '{752,  752, 0, 1'b1, 1'b0, 1'b0},
        '{799,  799, 0, 1'b1, 1'b0, 1'b1},
        '{800,  0,   1, 1'b1, 1'b1, 1'b0},
        '{1456, 656, 1, 1'b0, 1'b0, 1'b0}
    };

    // Hand-computed vectors for the reduced active-low instance.
    typedef struct { int c; int h; int v; bit vs; bit de; bit fe; } lo_vec_t;
    lo_vec_t lo_tab [8] = '{
        '{82,  7,  5,  1'b1, 1'b1, 1'b0},
        '{90,  0,  6,  1'b1, 1'b0, 1'b0},
        '{119, 14, 7,  1'b1, 1'b0, 1'b0},
        '{120, 0,  8,  1'b0, 1'b0, 1'b0},
        '{149, 14, 9,  1'b0, 1'b0, 1'b0},
        '{150, 0,  10, 1'b1, 1'b0, 1'b0},
        '{194, 14, 12, 1'b1, 1'b0, 1'b1},
        '{195, 0,  0,  1'b1, 1'b1, 1'b0}
    };

    // Hand-computed sync levels for the reduced active-high instance.
    typedef struct { int c; bit hs; bit vs; } hi_vec_t;
    hi_vec_t hi_tab [8] = '{
        '{9,   1'b0, 1'b0},
        '{10,  1'b1, 1'b0},
        '{12,  1'b1, 1'b0},
        '{13,  1'b0, 1'b0},
        '{119, 1'b0, 1'b0},
        '{120, 1'b0, 1'b1},
        '{149, 1'b0, 1'b1},
        '{150, 1'b0, 1'b0}
    };

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Position c clocks after reset release, and every output it implies.
    task automatic check_model(input string tag, input int c,
                               input int hd, input int hf, input int hs, input int hb,
                               input int vd, input int vf, input int vs, input int vb,
                               input bit active_low,
                               input logic [9:0] hp, input logic [9:0] vp,
                               input logic hsy, input logic vsy, input logic de,
                               input logic le, input logic fe);
        int ht;
        int vt;
        int eh;
        int ev;
        bit hw;
        bit vw;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        eh = c % ht;
        ev = (c / ht) % vt;
        hw = (eh >= hd + hf) && (eh < hd + hf + hs);
        vw = (ev >= vd + vf) && (ev < vd + vf + vs);
        chk({tag, ".hpos"},       32'(hp),  32'(eh));
        chk({tag, ".vpos"},       32'(vp),  32'(ev));
        chk({tag, ".hsync"},      32'(hsy), 32'(active_low ? !hw : hw));
        chk({tag, ".vsync"},      32'(vsy), 32'(active_low ? !vw : vw));
        chk({tag, ".display_on"}, 32'(de),  32'((eh < hd) && (ev < vd)));
        chk({tag, ".line_end"},   32'(le),  32'(eh == ht - 1));
        chk({tag, ".frame_end"},  32'(fe),  32'((eh == ht - 1) && (ev == vt - 1)));
    endtask

    task automatic sample_all();
        check_model("def", cyc, H_DISPLAY, H_FRONT, H_SYNC, H_BACK,
                    V_DISPLAY, V_FRONT, V_SYNC, V_BACK, 1'b1,
                    def_if.hpos, def_if.vpos, def_if.hsync, def_if.vsync,
                    def_if.display_on, def_if.line_end, def_if.frame_end);
        check_model("lo", cyc, SH_D, SH_F, SH_S, SH_B, SV_D, SV_F, SV_S, SV_B, 1'b1,
                    lo_if.hpos, lo_if.vpos, lo_if.hsync, lo_if.vsync,
                    lo_if.display_on, lo_if.line_end, lo_if.frame_end);
        check_model("hi", cyc, SH_D, SH_F, SH_S, SH_B, SV_D, SV_F, SV_S, SV_B, 1'b0,
                    hi_if.hpos, hi_if.vpos, hi_if.hsync, hi_if.vsync,
                    hi_if.display_on, hi_if.line_end, hi_if.frame_end);
    endtask

    task automatic directed();
        for (int i = 0; i < 10; i++) begin
            if (def_tab[i].c == cyc) begin
                chk("vec_def.hpos",       32'(def_if.hpos),       32'(def_tab[i].h));
                chk("vec_def.vpos",       32'(def_if.vpos),       32'(def_tab[i].v));
                chk("vec_def.hsync",      32'(def_if.hsync),      32'(def_tab[i].hs));
                chk("vec_def.display_on", 32'(def_if.display_on), 32'(def_tab[i].de));
                chk("vec_def.line_end",   32'(def_if.line_end),   32'(def_tab[i].le));
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (lo_tab[i].c == cyc) begin
                chk("vec_lo.hpos",       32'(lo_if.hpos),       32'(lo_tab[i].h));
                chk("vec_lo.vpos",       32'(lo_if.vpos),       32'(lo_tab[i].v));
                chk("vec_lo.vsync",      32'(lo_if.vsync),      32'(lo_tab[i].vs));
                chk("vec_lo.display_on", 32'(lo_if.display_on), 32'(lo_tab[i].de));
                chk("vec_lo.frame_end",  32'(lo_if.frame_end),  32'(lo_tab[i].fe));
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (hi_tab[i].c == cyc) begin
                chk("vec_hi.hsync", 32'(hi_if.hsync), 32'(hi_tab[i].hs));
                chk("vec_hi.vsync", 32'(hi_if.vsync), 32'(hi_tab[i].vs));
            end
        end
    endtask

    // Pulse-width and frame-period bookkeeping from observed outputs.
    task automatic track_pulses();
        if (def_if.hsync === 1'b0) hs_low++;
        if (cyc % H_TOTAL == H_TOTAL - 1) begin
            chk("def.hsync_width", 32'(hs_low), 32'(H_SYNC));
            hs_low = 0;
        end
        if (lo_if.vsync === 1'b0) vs_low++;
        if (cyc % S_FRAME == S_FRAME - 1) begin
            chk("lo.vsync_width", 32'(vs_low), 32'(SV_S * S_HT));
            vs_low = 0;
        end
        if (lo_if.frame_end === 1'b1) begin
            if (last_fe < 0) chk("lo.frame_end_first", 32'(cyc), 32'(S_FRAME - 1));
            else             chk("lo.frame_period", 32'(cyc - last_fe), 32'(S_FRAME));
            last_fe = cyc;
        end
    endtask

    // ---------------- driver ----------------
    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            sample_all();
            directed();
            track_pulses();
        end
    endtask

    task automatic restart_tracking();
        cyc     = 0;
        hs_low  = 0;
        vs_low  = 0;
        last_fe = -1;
    endtask

    initial begin
        reset = 1'b0;
        restart_tracking();

        // Held in reset for 5 clocks: everything at its (0,0) value.
        repeat (5) begin
            @(negedge clk);
            sample_all();
        end
        chk("rst.def_hsync",      32'(def_if.hsync),      32'd1);
        chk("rst.def_vsync",      32'(def_if.vsync),      32'd1);
        chk("rst.def_display_on", 32'(def_if.display_on), 32'd1);
        chk("rst.hi_hsync",       32'(hi_if.hsync),       32'd0);

        // Release away from the rising edge; first edge takes hpos to 1.
        reset = 1'b1;
        run(1700);

        // Walk the reduced frame to (h=11, v=8): both syncs active there.
        while (cyc % S_FRAME != 8 * S_HT + 11) run(1);
        chk("pre_mid.lo_hsync", 32'(lo_if.hsync), 32'd0);
        chk("pre_mid.lo_vsync", 32'(lo_if.vsync), 32'd0);

        // Mid-frame reset takes effect without waiting for a clock edge.
        reset = 1'b0;
        #1;
        cyc = 0;
        sample_all();
        chk("mid_rst.lo_hpos",  32'(lo_if.hpos),  32'd0);
        chk("mid_rst.lo_vpos",  32'(lo_if.vpos),  32'd0);
        chk("mid_rst.lo_hsync", 32'(lo_if.hsync), 32'd1);
        chk("mid_rst.lo_vsync", 32'(lo_if.vsync), 32'd1);
        chk("mid_rst.def_hpos", 32'(def_if.hpos), 32'd0);
        repeat (2) begin
            @(negedge clk);
            sample_all();
        end

        reset = 1'b1;
        restart_tracking();
        run(420);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
